// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register-file write-port arbiter between WB stage and long-latency unit
module rf_write_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        wb_we_i,
    input  logic [4:0]  wb_waddr_i,
    input  logic [31:0] wb_wdata_i,

    input  logic        ll_valid_i,
    input  logic [4:0]  ll_waddr_i,
    input  logic [31:0] ll_wdata_i,
    output logic        ll_ready_o,

    output logic        stall_req_o,

    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic             wb_eff;
    logic             addr_match;
    logic             ll_ready;
    logic             xfer;
    logic             wb_grant;
    logic             ll_grant;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;

    // Per-cycle grant: WB always wins the port; a colliding long-latency
    // result is older than the WB write, so it is consumed and dropped.
    // Writes to r0 are never issued but still complete the handshake.
    always_comb begin
        wb_eff     = wb_we_i && (wb_waddr_i != 5'd0);
        addr_match = (ll_waddr_i == wb_waddr_i);
        ll_ready   = 1'b0;
        wb_grant   = 1'b0;
        ll_grant   = 1'b0;
        if (!rst) begin
            if (wb_eff) begin
                wb_grant = 1'b1;
                ll_ready = ll_valid_i && addr_match;
            end else if (ll_valid_i) begin
                ll_ready = 1'b1;
                ll_grant = (ll_waddr_i != 5'd0);
            end
        end
        xfer = ll_valid_i && ll_ready;
    end

    assign ll_ready_o = ll_ready;

    // Refusal counter: counts consecutive refused cycles of a pending
    // long-latency result, saturating at MAX_WAIT.
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (!ll_valid_i || xfer) begin
            wait_cnt_nxt = '0;
        end else if (wait_cnt != MAX_CNT) begin
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
    end

    // Counter and bubble request; the request tracks the saturated counter,
    // so a transfer on the saturating cycle keeps it low.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            stall_req_o <= 1'b0;
        end else begin
            wait_cnt    <= wait_cnt_nxt;
            stall_req_o <= (wait_cnt_nxt == MAX_CNT);
        end
    end

    // Write-port register: one-cycle latency; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= 5'd0;
            rf_wdata_o <= 32'd0;
        end else if (wb_grant) begin
            rf_we_o    <= 1'b1;
            rf_waddr_o <= wb_waddr_i;
            rf_wdata_o <= wb_wdata_i;
        end else if (ll_grant) begin
            rf_we_o    <= 1'b1;
            rf_waddr_o <= ll_waddr_i;
            rf_wdata_o <= ll_wdata_i;
        end else begin
            rf_we_o    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - scoreboard bench for rf_write_arbiter
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;
    logic        ll_valid_i;
    logic [4:0]  ll_waddr_i;
    logic [31:0] ll_wdata_i;
    logic        ll_ready_o;
    logic        stall_req_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t sb[$];
    int  n_vec = 0;
    int  n_bad = 0;
    int  exp_cnt = 0;
    logic exp_stall = 1'b0;
    logic last_xfer = 1'b0;

    rf_write_arbiter #(.MAX_WAIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
        .ll_valid_i(ll_valid_i), .ll_waddr_i(ll_waddr_i), .ll_wdata_i(ll_wdata_i),
        .ll_ready_o(ll_ready_o), .stall_req_o(stall_req_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic lv, input logic [4:0] la, input logic [31:0] ld);
        rst = r; wb_we_i = we; wb_waddr_i = wa; wb_wdata_i = wd;
        ll_valid_i = lv; ll_waddr_i = la; ll_wdata_i = ld;
    endtask

    // One cycle: inputs already driven just after a rising edge.
    task automatic step();
        logic wb_eff;
        logic exp_ready;
        wr_t  w;
        logic was_rst;
        @(negedge clk);
        wb_eff    = wb_we_i && (wb_waddr_i != 5'd0);
        exp_ready = !rst && ll_valid_i && (wb_eff ? (ll_waddr_i == wb_waddr_i) : 1'b1);
        chk("ll_ready", 32'(ll_ready_o), 32'(exp_ready));
        if (!rst) begin
            if (wb_eff) begin
                w.a = wb_waddr_i; w.d = wb_wdata_i; sb.push_back(w);
            end else if (ll_valid_i && ll_waddr_i != 5'd0) begin
                w.a = ll_waddr_i; w.d = ll_wdata_i; sb.push_back(w);
            end
        end
        last_xfer = ll_valid_i && exp_ready;
        if (rst || !ll_valid_i || last_xfer) exp_cnt = 0;
        else if (exp_cnt < 4) exp_cnt++;
        exp_stall = (exp_cnt == 4);
        was_rst = rst;
        @(posedge clk);
        #1;
        chk("stall_req", 32'(stall_req_o), 32'(exp_stall));
        if (sb.size() > 0) begin
            w = sb.pop_front();
            chk("rf_we", 32'(rf_we_o), 32'd1);
            chk("rf_waddr", 32'(rf_waddr_o), 32'(w.a));
            chk("rf_wdata", rf_wdata_o, w.d);
        end else begin
            chk("rf_we_idle", 32'(rf_we_o), 32'd0);
            if (was_rst) begin
                chk("rst_waddr", 32'(rf_waddr_o), 32'd0);
                chk("rst_wdata", rf_wdata_o, 32'd0);
            end
        end
    endtask

    initial begin
        logic       lv;
        logic [4:0] la;
        logic [31:0] ld;

        // T1: reset held with a pending long-latency result
        set_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h0000_0606);
        @(posedge clk); #1;
        step(); step();
        set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h0000_0606);
        step();
        // T2: plain WB write
        set_in(1'b0, 1'b1, 5'd5, 32'hAAAA_0001, 1'b0, 5'd0, 32'd0);
        step();
        // T3: WB write to r0 is suppressed, ll takes the port
        set_in(1'b0, 1'b1, 5'd0, 32'h0000_0BAD, 1'b0, 5'd0, 32'd0);
        step();
        set_in(1'b0, 1'b1, 5'd0, 32'h0000_0BAD, 1'b1, 5'd7, 32'h7777_0007);
        step();
        set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        // T4: starved ll result, bubble at cycle 7
        for (int c = 1; c <= 6; c++) begin
            set_in(1'b0, 1'b1, 5'd3, 32'h3000_0000 + 32'(c), 1'b1, 5'd9, 32'h1234_5678);
            step();
        end
        chk("t4_stall_before_bubble", 32'(stall_req_o), 32'd1);
        set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1234_5678);
        step();
        chk("t4_stall_after_xfer", 32'(stall_req_o), 32'd0);
        set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        // T5: collision, WB supersedes
        set_in(1'b0, 1'b1, 5'd4, 32'h0000_BEEF, 1'b1, 5'd4, 32'h0000_DEAD);
        step();
        set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step(); step();
        // T6: reset while stall is up, then the count restarts
        for (int c = 0; c < 5; c++) begin
            set_in(1'b0, 1'b1, 5'd3, 32'h6000_0000 + 32'(c), 1'b1, 5'd10, 32'hA0A0_0A0A);
            step();
        end
        set_in(1'b1, 1'b1, 5'd3, 32'h6000_00FF, 1'b1, 5'd10, 32'hA0A0_0A0A);
        step();
        chk("t6_stall_cleared", 32'(stall_req_o), 32'd0);
        for (int c = 0; c < 5; c++) begin
            set_in(1'b0, 1'b1, 5'd3, 32'h6100_0000 + 32'(c), 1'b1, 5'd10, 32'hA0A0_0A0A);
            step();
        end
        set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA0A0_0A0A);
        step();

        // Random traffic honouring the hold-until-transfer rule
        lv = 1'b0; la = 5'd0; ld = 32'd0;
        for (int i = 0; i < 400; i++) begin
            if (last_xfer) lv = 1'b0;
            if (!lv && ($urandom_range(0, 2) == 0)) begin
                lv = 1'b1;
                la = 5'($urandom_range(0, 7));
                ld = $urandom;
            end
            set_in(($urandom_range(0, 59) == 0),
                   ($urandom_range(0, 9) < 7),
                   5'($urandom_range(0, 7)),
                   $urandom, lv, la, ld);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
